// File: rtl/dvi_timing_gen.sv
// Raster timing generator with PIX_LAT-aligned sync/DE/data output stage for a DVI encoder.
// Optional colour-bar test pattern enabled by defining DVI_TIMING_TPG_EN.
module dvi_timing_gen #(
  parameter int CORDW   = 16,
  parameter int H_RES   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_RES   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int H_POL   = 0,
  parameter int V_POL   = 0,
  parameter int PIX_LAT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
`ifdef DVI_TIMING_TPG_EN
  input  logic             i_tpg,
`endif
  output logic             o_req,
  output logic [CORDW-1:0] o_sx,
  output logic [CORDW-1:0] o_sy,
  output logic             o_frame,
  output logic             o_line,
  input  logic [7:0]       i_red,
  input  logic [7:0]       i_green,
  input  logic [7:0]       i_blue,
  output logic             o_de,
  output logic [7:0]       o_data_ch0,
  output logic [7:0]       o_data_ch1,
  output logic [7:0]       o_data_ch2,
  output logic [1:0]       o_ctrl_ch0,
  output logic [1:0]       o_ctrl_ch1,
  output logic [1:0]       o_ctrl_ch2
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int PW      = PIX_LAT + 1;

  localparam logic [CORDW-1:0] H_MAX    = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_MAX    = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  logic [CORDW-1:0] cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
  logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic             line_q, line_d, frame_q, frame_d;
  logic             req0, hs0, vs0;
  // Index 0 is the stage-0 register; index PIX_LAT is the one that meets the returning RGB.
  logic [PIX_LAT:0] req_q, req_d, hs_q, hs_d, vs_q, vs_d;
  logic             de_q, de_d;
  logic [7:0]       d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [7:0]       red, green, blue;

`ifdef DVI_TIMING_TPG_EN
  localparam int XW = CORDW + 3;
  localparam int BW = 3 * PW;
  logic [2:0]            bar0;
  logic [PIX_LAT:0][2:0] bar_q, bar_d;
`endif

  always_comb begin
    cnt_x_d = cnt_x_q + 1'b1;
    cnt_y_d = cnt_y_q;
    if (cnt_x_q == H_MAX) begin
      cnt_x_d = '0;
      cnt_y_d = (cnt_y_q == V_MAX) ? '0 : cnt_y_q + 1'b1;
    end

    sx_d    = cnt_x_q;
    sy_d    = cnt_y_q;
    line_d  = (cnt_x_q == '0);
    frame_d = (cnt_x_q == '0) && (cnt_y_q == '0);
    req0    = (cnt_x_q < H_ACT) && (cnt_y_q < V_ACT);
    hs0     = ((cnt_x_q >= HS_START) && (cnt_x_q < HS_END)) ? HS_ON : ~HS_ON;
    vs0     = ((cnt_y_q >= VS_START) && (cnt_y_q < VS_END)) ? VS_ON : ~VS_ON;

    req_d = PW'({req_q, req0});
    hs_d  = PW'({hs_q, hs0});
    vs_d  = PW'({vs_q, vs0});

    red   = i_red;
    green = i_green;
    blue  = i_blue;
`ifdef DVI_TIMING_TPG_EN
    // floor(sx*8/H_RES) as a count of bar thresholds crossed, avoiding a divider.
    bar0 = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if ({cnt_x_q, 3'b000} >= XW'(k * H_RES)) bar0 = 3'(k);
    end
    bar_d = BW'({bar_q, bar0});
    if (i_tpg) begin
      red   = {8{bar_q[PIX_LAT][2]}};
      green = {8{bar_q[PIX_LAT][1]}};
      blue  = {8{bar_q[PIX_LAT][0]}};
    end
`endif

    de_d   = req_q[PIX_LAT];
    d0_d   = de_d ? blue  : '0;
    d1_d   = de_d ? green : '0;
    d2_d   = de_d ? red   : '0;
    ctrl_d = {vs_q[PIX_LAT], hs_q[PIX_LAT]};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_x_q <= '0;
      cnt_y_q <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      req_q   <= '0;
      hs_q    <= {PW{~HS_ON}};
      vs_q    <= {PW{~VS_ON}};
      de_q    <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      ctrl_q  <= {~VS_ON, ~HS_ON};
`ifdef DVI_TIMING_TPG_EN
      bar_q   <= '0;
`endif
    end else begin
      cnt_x_q <= cnt_x_d;
      cnt_y_q <= cnt_y_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      req_q   <= req_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      ctrl_q  <= ctrl_d;
`ifdef DVI_TIMING_TPG_EN
      bar_q   <= bar_d;
`endif
    end
  end

  assign o_req      = req_q[0];
  assign o_sx       = sx_q;
  assign o_sy       = sy_q;
  assign o_line     = line_q;
  assign o_frame    = frame_q;
  assign o_de       = de_q;
  assign o_data_ch0 = d0_q;
  assign o_data_ch1 = d1_q;
  assign o_data_ch2 = d2_q;
  assign o_ctrl_ch0 = ctrl_q;
  assign o_ctrl_ch1 = 2'b00;
  assign o_ctrl_ch2 = 2'b00;

endmodule

// File: doc/dvi_timing_gen.md
Name: dvi_timing_gen

Overview:
- Raster timing generator and pixel-alignment stage.
- Sits directly upstream of the DVI generator and drives its i_de, i_data_ch0..2 and i_ctrl_ch0..2 inputs on the pixel clock.
- Issues pixel requests with screen coordinates to a pixel source (framebuffer or renderer) and accepts RGB back a fixed PIX_LAT cycles later.
- Delays sync and DE by the same latency so data, DE and sync leave the block aligned.

Parameters:
- CORDW, 16, coordinate counter width; must satisfy 2^CORDW > max(H_TOTAL, V_TOTAL).
- H_RES, 640, active pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_RES, 480, active lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync width (lines).
- V_BP, 33, vertical back porch (lines).
- H_POL, 0, hsync active level (0 = active-low, 1 = active-high).
- V_POL, 0, vsync active level.
- PIX_LAT, 2, request-to-data latency of the pixel source, 0..8.

Ports:
- i_clk  in  1  pixel clock.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- o_req  out  1  pixel request; high for active-area positions.
- o_sx  out  CORDW  horizontal coordinate of the current request position.
- o_sy  out  CORDW  vertical coordinate of the current request position.
- o_frame  out  1  one-cycle strobe at request position (0,0).
- o_line  out  1  one-cycle strobe at sx=0 of every line.
- i_red  in  8  pixel red, valid PIX_LAT cycles after the matching o_req.
- i_green  in  8  pixel green, same timing as i_red.
- i_blue  in  8  pixel blue, same timing as i_red.
- o_de  out  1  display enable to the DVI generator.
- o_data_ch0  out  8  blue.
- o_data_ch1  out  8  green.
- o_data_ch2  out  8  red.
- o_ctrl_ch0  out  2  {vsync, hsync}.
- o_ctrl_ch1  out  2  constant 2'b00.
- o_ctrl_ch2  out  2  constant 2'b00.

Behaviour:
- Counters and totals:
  - H_TOTAL = H_RES+H_FP+H_SYNC+H_BP; V_TOTAL = V_RES+V_FP+V_SYNC+V_BP.
  - sx counts 0..H_TOTAL-1 and wraps to 0. On wrap, sy increments; sy wraps 0 after V_TOTAL-1.
- Request-stage signals (stage 0), all registered:
  - o_sx and o_sy reflect the counters.
  - o_req = (sx < H_RES) && (sy < V_RES).
  - o_line = (sx == 0).
  - o_frame = (sx == 0 && sy == 0).
- Sync generation at stage 0:
  - hsync active iff H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC.
  - vsync active iff V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC, evaluated on sy, so it changes only at sx=0.
  - Active level is H_POL / V_POL; the inactive level is its inverse.
- Alignment pipeline:
  - req, hsync and vsync pass through a PIX_LAT-deep shift register.
  - i_red/i_green/i_blue are sampled on the cycle the delayed req emerges.
  - The output register then loads de, data and ctrl.
  - Total latency from stage 0 to o_de/o_ctrl/o_data is PIX_LAT+1 cycles.
  - Data sampled at cycle t+PIX_LAT appears on o_data one cycle later.
  - PIX_LAT=0: RGB is sampled in the same cycle o_req is high.
- Blanking: o_data_ch0..2 forced to 8'h00 whenever o_de=0, regardless of i_* values.
- Reset (i_rst_n low):
  - sx = sy = 0.
  - o_req, o_frame, o_line, o_de = 0; o_data = 0.
  - o_ctrl_ch0 = {~V_POL, ~H_POL}, i.e. sync inactive.
  - Every pipeline stage holds these inactive values.
- After reset release:
  - The first cycle is stage 0 at (0,0): o_frame=1, o_line=1, o_req=1 on the first edge following deassert.
  - The first o_de=1 occurs PIX_LAT+1 cycles later. Outputs stay inactive until the pipeline fills.
- Reset mid-frame: immediate async clear of all state. The raster restarts at (0,0) with no partial sync pulse continued.
- Boundary: sx wrap at H_TOTAL-1 and sy wrap at V_TOTAL-1 are back-to-back with no idle cycle. o_frame recurs exactly every H_TOTAL*V_TOTAL cycles.
- No handshake back-pressure: the pixel source must honour PIX_LAT exactly.

Optional Feature:
- Macro: DVI_TIMING_TPG_EN.
- Defined:
  - Adds input port i_tpg (1 bit). When i_tpg=1, i_red/i_green/i_blue are ignored and output data comes from an internal 8-bar colour pattern keyed on the delayed sx.
  - Bar index = (sx*8)/H_RES, computed at stage 0 and delayed with req.
  - Bar k drives red = {8{k[2]}}, green = {8{k[1]}}, blue = {8{k[0]}}.
  - Timing, latency and blanking are unchanged.
- Undefined: no i_tpg port, no pattern logic; data always comes from i_*.

Test Plan:
- Reduced raster (H_RES=8, H_FP=2, H_SYNC=3, H_BP=3, V_RES=4, V_FP=1, V_SYNC=2, V_BP=1, PIX_LAT=2) -> o_frame period exactly 16*8=128 cycles; o_line every 16; o_req high 8 of 16 cycles on lines 0..3 only.
- Same raster, i_red = sx-of-request delayed 2 cycles (source model) -> o_data_ch2 = 0,1,..,7 on the 8 o_de cycles of every active line; o_de rises 3 cycles after o_req rises.
- H_POL=0, V_POL=1 -> o_ctrl_ch0[0] low for exactly 3 cycles starting at (delayed) sx=10; o_ctrl_ch0[1] high for exactly 2 full lines starting at sy=5, sx=0 (+3 cycle offset).
- Drive i_red/green/blue=8'hFF constantly -> o_data_ch0..2 = 8'h00 whenever o_de=0; o_ctrl_ch1 = o_ctrl_ch2 = 2'b00 always.
- Assert i_rst_n low mid-line (sx=5, sy=2), hold 3 cycles, release -> all outputs inactive immediately during reset; o_frame=1 on the first edge after release; first o_de 3 cycles after that.
- PIX_LAT=0 with DVI_TIMING_TPG_EN defined, i_tpg=1 -> o_data for sx 0..7 follows bars 0..7 (sx=1 gives blue=8'hFF, red=green=8'h00); o_de 1 cycle after o_req.
